// File: rtl/mips20_pkg.sv
// mips20_pkg: shared widths, reset PC and fetch entry type for the 20-bit MIPS front end
package mips20_pkg;
  localparam int DEF_ADDR_W   = 20;
  localparam int DEF_DATA_W   = 20;
  localparam int DEF_RESET_PC = 0;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
  } instr_pc_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with push/pop/flush and a registered head entry
// Ports: clk, rst (async active-low); push_i/push_data_i write an entry; pop_i removes the
// head when valid_o; flush_i empties the FIFO and wins over push/pop; head_o is the
// registered head entry (holds its last value when empty); count_o is the occupancy.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q, rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_eff, push_eff;
  assign pop_eff  = pop_i & (count_q != '0) & ~flush_i;
  assign push_eff = push_i & ~flush_i;
  assign rd_nxt   = rd_q + PW'(1);
  assign valid_o  = count_q != '0;
  assign head_o   = head_q;
  assign count_o  = count_q;
  // The head register is loaded with whichever entry becomes the head at this edge:
  // the next stored entry after a pop, or the pushed word when it lands in an empty slot.
  always_comb begin
    count_d = flush_i ? '0 : count_q + CW'(push_eff) - CW'(pop_eff);
    head_d  = flush_i ? head_q :
              pop_eff ? ((count_q > CW'(1)) ? mem_q[rd_nxt] : (push_eff ? push_data_i : head_q)) :
              ((count_q == '0) && push_eff) ? push_data_i : head_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      if (flush_i) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push_eff) wr_q <= wr_q + PW'(1);
        if (pop_eff)  rd_q <= rd_nxt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_q] <= push_data_i;
  end
  // The requester's credit check guarantees a full FIFO is never pushed without a pop.
  always_ff @(posedge clk) begin
    if (rst) assert (!(push_eff && !pop_eff && count_q == CW'(DEPTH)));
  end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC generator, imem requester and prefetch FIFO feeding decode
// Ports: clk, rst (async active-low); fetch_en gates new requests; redirect_valid/redirect_pc
// flush and restart fetch; imem_req/imem_addr/imem_rdata form a 1-cycle-latency read port;
// id_valid/id_ready/id_instr/id_pc/id_pc_next is the decode handshake; fifo_count is occupancy.
module fetch_prefetch_unit
  import mips20_pkg::*;
#(
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter int              DATA_W     = DEF_DATA_W,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [DATA_W-1:0]             imem_rdata,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [DATA_W-1:0]             id_instr,
  output logic [ADDR_W-1:0]             id_pc,
  output logic [ADDR_W-1:0]             id_pc_next,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              inflight_epoch_q, inflight_epoch_d;
  logic              epoch_q, epoch_d;
  logic              seen_q, seen_d;
  logic [CW-1:0]     used;
  logic              issue, push;
  entry_t            push_entry, head;
  // Credit covers both stored entries and the response still on its way from memory.
  // Gating with rst keeps the request low the moment reset is asserted.
  assign used       = fifo_count + CW'(inflight_q);
  assign issue      = rst & fetch_en & ~redirect_valid & (used < CW'(FIFO_DEPTH));
  assign push       = inflight_q & ~redirect_valid & (inflight_epoch_q == epoch_q);
  assign push_entry = '{instr: imem_rdata, pc: inflight_pc_q};
  assign imem_req   = issue;
  assign imem_addr  = fetch_pc_q;
  assign id_instr   = head.instr;
  assign id_pc      = head.pc;
  // Until the first entry reaches the head, the next-PC output reads as zero like the head.
  assign id_pc_next = (seen_q | id_valid) ? head.pc + ADDR_W'(1) : '0;
  always_comb begin
    fetch_pc_d       = redirect_valid ? redirect_pc : issue ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
    inflight_d       = issue;
    inflight_pc_d    = issue ? fetch_pc_q : inflight_pc_q;
    inflight_epoch_d = issue ? epoch_q : inflight_epoch_q;
    epoch_d          = epoch_q ^ redirect_valid;
    seen_d           = seen_q | id_valid;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      seen_q           <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
      seen_q           <= seen_d;
    end
  end
  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W + ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (id_ready),
    .flush_i    (redirect_valid),
    .valid_o    (id_valid),
    .head_o     (head),
    .count_o    (fifo_count)
  );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed scenario bench for the fetch front end
module tb_fetch_prefetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [19:0] redirect_pc = '0;
  logic        imem_req;
  logic [19:0] imem_addr;
  logic [19:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [19:0] id_instr, id_pc, id_pc_next;
  logic [2:0]  fifo_count;
  int checks = 0;
  int failures = 0;

  fetch_prefetch_unit dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_next(id_pc_next), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= 20'h10000 | imem_addr;

  task automatic start(input logic ready);
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_en = 1'b1; id_ready = ready;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      if (c > 0) step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 20'(c)) begin
        failures++; $display("FAIL %s_req c%0d got req=%0b addr=%h exp req=1 addr=%h", tag, c, imem_req, imem_addr, 20'(c));
      end
      checks++;
      if (c < 2) begin
        if (id_valid !== 1'b0) begin
          failures++; $display("FAIL %s_early c%0d got id_valid=%0b exp 0", tag, c, id_valid);
        end
      end else if (id_valid !== 1'b1 || id_pc !== 20'(c-2) || id_instr !== (20'h10000 | 20'(c-2)) ||
                   id_pc_next !== 20'(c-1) || fifo_count !== 3'd1) begin
        failures++;
        $display("FAIL %s_head c%0d got v=%0b pc=%h instr=%h nxt=%h cnt=%0d exp v=1 pc=%h instr=%h nxt=%h cnt=1",
                 tag, c, id_valid, id_pc, id_instr, id_pc_next, fifo_count, 20'(c-2), 20'h10000 | 20'(c-2), 20'(c-1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_en = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got %0b exp 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %0b exp 0", id_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    checks++; if (id_instr !== 20'h0) begin failures++; $display("FAIL rst_instr got %h exp 0", id_instr); end
    checks++; if (id_pc !== 20'h0) begin failures++; $display("FAIL rst_pc got %h exp 0", id_pc); end
    checks++; if (id_pc_next !== 20'h0) begin failures++; $display("FAIL rst_pc_next got %h exp 0", id_pc_next); end
  endtask

  task automatic test_stream();
    start(1'b1);
    check_stream("s1", 8);
  endtask

  task automatic test_backpressure();
    int reqs = 0;
    start(1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      reqs += int'(imem_req);
    end
    checks++; if (reqs != 4) begin failures++; $display("FAIL bp_reqs got %0d exp 4", reqs); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL bp_count got %0d exp 4", fifo_count); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_full got %0b exp 0", imem_req); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      id_ready = 1'b1;
      #1;
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 20'(k) || id_instr !== (20'h10000 | 20'(k))) begin
        failures++; $display("FAIL bp_pop k%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h", k, id_valid, id_pc, id_instr, 20'(k));
      end
      if (k == 0) begin
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_k0 got %0b exp 0", imem_req); end
      end
      if (k == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 20'h4) begin
          failures++; $display("FAIL bp_resume got req=%0b addr=%h exp req=1 addr=00004", imem_req, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect();
    start(1'b1);
    repeat (5) step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 20'h5) begin
      failures++; $display("FAIL rd_pre got req=%0b addr=%h exp req=1 addr=00005", imem_req, imem_addr);
    end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 20'h40; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rd_noissue got %0b exp 0", imem_req); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 20'h40 || id_valid !== 1'b0) begin
      failures++; $display("FAIL rd_first got req=%0b addr=%h v=%0b exp req=1 addr=00040 v=0", imem_req, imem_addr, id_valid);
    end
    step();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rd_gap got v=%0b pc=%h exp v=0", id_valid, id_pc); end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 20'h40 || id_instr !== 20'h10040) begin
      failures++; $display("FAIL rd_head got v=%0b pc=%h instr=%h exp v=1 pc=00040 instr=10040", id_valid, id_pc, id_instr);
    end
    step();
    checks++; if (id_pc !== 20'h41) begin failures++; $display("FAIL rd_head2 got pc=%h exp 00041", id_pc); end
  endtask

  task automatic test_full_redirect();
    start(1'b0);
    repeat (5) step();
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fr_full got %0d exp 4", fifo_count); end
    @(negedge clk); id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 20'h100; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fr_noissue got %0b exp 0", imem_req); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++;
    if (fifo_count !== 3'd0 || id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 20'h100) begin
      failures++; $display("FAIL fr_flush got cnt=%0d v=%0b req=%0b addr=%h exp cnt=0 v=0 req=1 addr=00100", fifo_count, id_valid, imem_req, imem_addr);
    end
    step();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fr_stale got v=%0b pc=%h exp v=0", id_valid, id_pc); end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 20'h100 || id_instr !== 20'h10100) begin
      failures++; $display("FAIL fr_head got v=%0b pc=%h instr=%h exp v=1 pc=00100 instr=10100", id_valid, id_pc, id_instr);
    end
    step();
    checks++;
    if (id_pc !== 20'h101 || fifo_count !== 3'd1) begin
      failures++; $display("FAIL fr_head2 got pc=%h cnt=%0d exp pc=00101 cnt=1", id_pc, fifo_count);
    end
  endtask

  task automatic test_wrap();
    start(1'b1);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 20'hFFFFF; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 20'hFFFFF || id_valid !== 1'b0) begin
      failures++; $display("FAIL wr_req1 got req=%0b addr=%h v=%0b exp req=1 addr=fffff v=0", imem_req, imem_addr, id_valid);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 20'h0 || id_valid !== 1'b0) begin
      failures++; $display("FAIL wr_req2 got req=%0b addr=%h v=%0b exp req=1 addr=00000 v=0", imem_req, imem_addr, id_valid);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 20'hFFFFF || id_pc_next !== 20'h0 || id_instr !== 20'hFFFFF) begin
      failures++; $display("FAIL wr_head got v=%0b pc=%h nxt=%h instr=%h exp v=1 pc=fffff nxt=00000 instr=fffff", id_valid, id_pc, id_pc_next, id_instr);
    end
    step();
    checks++;
    if (id_pc !== 20'h0 || id_pc_next !== 20'h1 || id_instr !== 20'h10000) begin
      failures++; $display("FAIL wr_head2 got pc=%h nxt=%h instr=%h exp pc=00000 nxt=00001 instr=10000", id_pc, id_pc_next, id_instr);
    end
  endtask

  task automatic test_fetch_en();
    start(1'b1);
    @(negedge clk); fetch_en = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 20'h1) begin
      failures++; $display("FAIL fe_hold got req=%0b addr=%h exp req=0 addr=00001", imem_req, imem_addr);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 20'h0 || imem_req !== 1'b0 || imem_addr !== 20'h1) begin
      failures++; $display("FAIL fe_drain got v=%0b pc=%h req=%0b addr=%h exp v=1 pc=00000 req=0 addr=00001", id_valid, id_pc, imem_req, imem_addr);
    end
    @(negedge clk); fetch_en = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 20'h1 || id_valid !== 1'b0) begin
      failures++; $display("FAIL fe_resume got req=%0b addr=%h v=%0b exp req=1 addr=00001 v=0", imem_req, imem_addr, id_valid);
    end
  endtask

  task automatic test_async_reset();
    start(1'b0);
    repeat (4) step();
    checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL ar_pre got cnt=%0d exp 3", fifo_count); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0 || fifo_count !== 3'd0) begin
      failures++; $display("FAIL ar_now got v=%0b req=%0b cnt=%0d exp 0 0 0", id_valid, imem_req, fifo_count);
    end
    start(1'b1);
    check_stream("s6", 6);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_full_redirect();
    test_wrap();
    test_fetch_en();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
